neuron_mac_ctrl: RTL

//  Control FSM that sequences one neuron evaluation on the single-MAC datapath (x/w regs, multiplier, adder, accumulator, activation, result reg).

---
 rtl/neuron_pkg.sv | 20 ++
 rtl/neuron_mac_ctrl.sv | 119 +++++++++++
 2 files changed

// File: rtl/neuron_pkg.sv
// Shared types for the neuron MAC controller: sequencing states and the
// operand-address width helper also used to size the x/w memories.
package neuron_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StClr,
        StFetch,
        StLoad,
        StMac,
        StAct,
        StWrite,
        StDone
    } state_e;

    function automatic int unsigned addr_w(input int unsigned d);
        return (d > 1) ? $clog2(d) : 1;
    endfunction

endpackage

// File: rtl/neuron_mac_ctrl.sv
// Sequences one neuron evaluation on the single-MAC datapath: clear, D fetch/load/MAC
// rounds, activation, result write, done pulse. Abort returns to idle via an accumulator clear.
module neuron_mac_ctrl
    import neuron_pkg::*;
#(
    parameter int unsigned D      = 8,
    parameter int unsigned ADDR_W = addr_w(D)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic              i_in_valid,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_x_write,
    output logic              o_w_write,
    output logic              o_clear_acc,
    output logic              o_acc_en,
    output logic              o_ready,
    output logic              o_res_write,
    output logic              o_busy,
    output logic              o_done
);

    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(D - 1);

    state_e            r_state;
    state_e            w_state_next;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] w_idx_next;
    // Set for the single idle cycle that follows an abort, so the accumulator is wiped.
    logic              r_abort_clr;
    logic              w_abort_clr_next;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_idx       <= '0;
            r_abort_clr <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_idx       <= w_idx_next;
            r_abort_clr <= w_abort_clr_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_idx_next       = r_idx;
        w_abort_clr_next = 1'b0;
        o_addr           = '0;
        o_x_write        = 1'b0;
        o_w_write        = 1'b0;
        o_clear_acc      = 1'b0;
        o_acc_en         = 1'b0;
        o_ready          = 1'b0;
        o_res_write      = 1'b0;
        o_busy           = (r_state != StIdle);
        o_done           = 1'b0;

        unique case (r_state)
            StIdle: begin
                o_clear_acc = r_abort_clr;
                if (i_start) begin
                    w_state_next = StClr;
                end
            end
            StClr: begin
                o_clear_acc  = 1'b1;
                w_idx_next   = '0;
                w_state_next = StFetch;
            end
            StFetch: begin
                o_addr       = r_idx;
                w_state_next = StLoad;
            end
            StLoad: begin
                o_addr = r_idx;
                // Strobes qualified by in_valid so a stalled load never captures stale data.
                if (i_in_valid) begin
                    o_x_write    = 1'b1;
                    o_w_write    = 1'b1;
                    w_state_next = StMac;
                end
            end
            StMac: begin
                o_acc_en = 1'b1;
                if (r_idx == LastIdx) begin
                    w_state_next = StAct;
                end else begin
                    w_idx_next   = r_idx + ADDR_W'(1);
                    w_state_next = StFetch;
                end
            end
            StAct: begin
                o_ready      = 1'b1;
                w_state_next = StWrite;
            end
            StWrite: begin
                o_res_write  = 1'b1;
                w_state_next = StDone;
            end
            StDone: begin
                o_done       = 1'b1;
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase

        if ((r_state != StIdle) && i_abort) begin
            w_state_next     = StIdle;
            w_idx_next       = '0;
            w_abort_clr_next = 1'b1;
        end
    end

endmodule
